// File: rtl/bp_if.sv
// Lookup/update/statistics bundle between the IF/ID stages and the branch predictor.
interface bp_if #(
  parameter int PC_W   = 32,
  parameter int STAT_W = 32
);
  logic [PC_W-1:0]   lkp_pc;
  logic              lkp_hit;
  logic              lkp_taken;
  logic [PC_W-1:0]   lkp_target;
  logic              upd_valid;
  logic [PC_W-1:0]   upd_pc;
  logic              upd_taken;
  logic [PC_W-1:0]   upd_target;
  logic              upd_pred_taken;
  logic [PC_W-1:0]   upd_pred_target;
  logic              bp_clear;
  logic              upd_mispredict;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  modport master (
    output lkp_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, bp_clear,
    input  lkp_hit, lkp_taken, lkp_target, upd_mispredict,
           stat_branches, stat_mispredicts
  );

  modport slave (
    input  lkp_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, bp_clear,
    output lkp_hit, lkp_taken, lkp_target, upd_mispredict,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/riscv_branch_predictor.sv
// Direct-mapped BHT+BTB: combinational lookup for IF, single-port training from ID,
// saturating mispredict statistics.
module bp_entry #(
  parameter int TAG_W = 26,
  parameter int PC_W  = 32,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic             valid_d_i,
  input  logic [TAG_W-1:0] tag_d_i,
  input  logic [PC_W-1:0]  tgt_d_i,
  input  logic [CNT_W-1:0] ctr_d_i,
  output logic             valid_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [PC_W-1:0]  tgt_o,
  output logic [CNT_W-1:0] ctr_o
);
  localparam logic [CNT_W-1:0] CTR_MAX = '1;
  localparam logic [CNT_W-1:0] CTR_WNT = CTR_MAX >> 1;

  logic             valid_q;
  logic [TAG_W-1:0] tag_q;
  logic [PC_W-1:0]  tgt_q;
  logic [CNT_W-1:0] ctr_q;

  // Clear keeps tag/target; only validity and confidence are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      tgt_q   <= '0;
      ctr_q   <= CTR_WNT;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      ctr_q   <= CTR_WNT;
    end else if (wr_i) begin
      valid_q <= valid_d_i;
      tag_q   <= tag_d_i;
      tgt_q   <= tgt_d_i;
      ctr_q   <= ctr_d_i;
    end
  end

  assign valid_o = valid_q;
  assign tag_o   = tag_q;
  assign tgt_o   = tgt_q;
  assign ctr_o   = ctr_q;
endmodule

module riscv_branch_predictor #(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic clk,
  input  logic rst_n,
  bp_if.slave  bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CTR_MAX = '1;
  localparam logic [CNT_W-1:0] CTR_WT  = CTR_MAX ^ (CTR_MAX >> 1);

  logic [ENTRIES-1:0]            vld_arr;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_arr;
  logic [ENTRIES-1:0][PC_W-1:0]  tgt_arr;
  logic [ENTRIES-1:0][CNT_W-1:0] ctr_arr;

  logic [IDX_W-1:0] lkp_idx, upd_idx;
  logic [TAG_W-1:0] lkp_tag, upd_tag;
  logic             lkp_hit, upd_hit, upd_we;
  logic [PC_W-1:0]  tgt_d;
  logic [CNT_W-1:0] ctr_d, upd_ctr;
  logic [STAT_W-1:0] stat_br_q, stat_mp_q;
  logic             mispredict;
  logic             unused_pc_lsb;

  assign lkp_idx = bp.lkp_pc[IDX_W+1:2];
  assign lkp_tag = bp.lkp_pc[PC_W-1:IDX_W+2];
  assign upd_idx = bp.upd_pc[IDX_W+1:2];
  assign upd_tag = bp.upd_pc[PC_W-1:IDX_W+2];
  assign unused_pc_lsb = ^{bp.lkp_pc[1:0], bp.upd_pc[1:0]};

  // Lookup reads pre-edge state; a same-cycle update is not bypassed.
  assign lkp_hit       = vld_arr[lkp_idx] && (tag_arr[lkp_idx] == lkp_tag);
  assign bp.lkp_hit    = lkp_hit;
  assign bp.lkp_taken  = lkp_hit && ctr_arr[lkp_idx][CNT_W-1];
  assign bp.lkp_target = bp.lkp_taken ? tgt_arr[lkp_idx] : bp.lkp_pc + PC_W'(4);

  assign upd_hit = vld_arr[upd_idx] && (tag_arr[upd_idx] == upd_tag);
  assign upd_ctr = ctr_arr[upd_idx];

  always_comb begin
    upd_we = 1'b0;
    ctr_d  = upd_ctr;
    tgt_d  = tgt_arr[upd_idx];
    if (bp.upd_valid && !bp.bp_clear) begin
      if (upd_hit) begin
        upd_we = 1'b1;
        if (bp.upd_taken) begin
          ctr_d = (upd_ctr == CTR_MAX) ? upd_ctr : upd_ctr + CNT_W'(1);
          tgt_d = bp.upd_target;
        end else begin
          ctr_d = (upd_ctr == '0) ? upd_ctr : upd_ctr - CNT_W'(1);
        end
      end else if (bp.upd_taken) begin
        upd_we = 1'b1;
        ctr_d  = CTR_WT;
        tgt_d  = bp.upd_target;
      end
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    bp_entry #(.TAG_W(TAG_W), .PC_W(PC_W), .CNT_W(CNT_W)) u_ent (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (bp.bp_clear),
      .wr_i      (upd_we && (upd_idx == IDX_W'(g))),
      .valid_d_i (1'b1),
      .tag_d_i   (upd_tag),
      .tgt_d_i   (tgt_d),
      .ctr_d_i   (ctr_d),
      .valid_o   (vld_arr[g]),
      .tag_o     (tag_arr[g]),
      .tgt_o     (tgt_arr[g]),
      .ctr_o     (ctr_arr[g])
    );
  end

  assign mispredict = bp.upd_valid &&
                      ((bp.upd_taken != bp.upd_pred_taken) ||
                       (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));
  assign bp.upd_mispredict = mispredict;

  // Statistics still count updates that a concurrent clear discards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (bp.upd_valid && (stat_br_q != '1)) stat_br_q <= stat_br_q + STAT_W'(1);
      if (mispredict && (stat_mp_q != '1))   stat_mp_q <= stat_mp_q + STAT_W'(1);
    end
  end

  assign bp.stat_branches    = stat_br_q;
  assign bp.stat_mispredicts = stat_mp_q;
endmodule

// File: tb/tb_riscv_branch_predictor.sv
// Directed checks of the branch predictor: allocation, hysteresis, aliasing,
// same-cycle ordering, clear, async reset and statistics.
module tb_riscv_branch_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   exp_br = 0;
  int   exp_mp = 0;

  bp_if #(.PC_W(32), .STAT_W(32)) bus ();

  riscv_branch_predictor #(.PC_W(32), .ENTRIES(16), .CNT_W(2), .STAT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic lkp(input string tag, input logic [31:0] pc, input logic hit,
                     input logic tk, input logic [31:0] tgt);
    bus.lkp_pc = pc;
    #1;
    chk({tag, ".hit"},    32'(bus.lkp_hit),   32'(hit));
    chk({tag, ".taken"},  32'(bus.lkp_taken), 32'(tk));
    chk({tag, ".target"}, bus.lkp_target,     tgt);
  endtask

  // Drives one resolved branch for a full cycle; checks mispredict before the edge.
  task automatic upd(input string tag, input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    logic mp;
    bus.upd_valid = 1'b1;
    bus.upd_pc = pc;
    bus.upd_taken = tk;
    bus.upd_target = tgt;
    bus.upd_pred_taken = ptk;
    bus.upd_pred_target = ptgt;
    mp = (tk != ptk) || (tk && (tgt != ptgt));
    #1;
    chk({tag, ".mispredict"}, 32'(bus.upd_mispredict), 32'(mp));
    exp_br++;
    if (mp) exp_mp++;
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, ".branches"},    bus.stat_branches,    32'(exp_br));
    chk({tag, ".mispredicts"}, bus.stat_mispredicts, 32'(exp_mp));
  endtask

  initial begin
    bus.lkp_pc = 32'h40;
    bus.upd_valid = 1'b0;
    bus.upd_pc = '0;
    bus.upd_taken = 1'b0;
    bus.upd_target = '0;
    bus.upd_pred_taken = 1'b0;
    bus.upd_pred_target = '0;
    bus.bp_clear = 1'b0;

    // Reset state
    lkp("rst", 32'h40, 0, 0, 32'h44);
    chk_stats("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Allocation on a taken miss
    upd("alloc", 32'h40, 1, 32'h100, 0, 32'h0);
    lkp("alloc", 32'h40, 1, 1, 32'h100);
    chk_stats("alloc");

    // Hysteresis and saturation at both ends
    upd("h_t1", 32'h40, 1, 32'h100, 1, 32'h100);
    upd("h_t2", 32'h40, 1, 32'h100, 1, 32'h100);
    upd("h_n1", 32'h40, 0, 32'h0, 1, 32'h100);
    lkp("h_n1", 32'h40, 1, 1, 32'h100);
    upd("h_n2", 32'h40, 0, 32'h0, 1, 32'h100);
    lkp("h_n2", 32'h40, 1, 0, 32'h44);
    upd("h_n3", 32'h40, 0, 32'h0, 0, 32'h0);
    upd("h_n4", 32'h40, 0, 32'h0, 0, 32'h0);
    upd("h_n5", 32'h40, 0, 32'h0, 0, 32'h0);
    lkp("h_sat0", 32'h40, 1, 0, 32'h44);
    upd("h_t3", 32'h40, 1, 32'h100, 0, 32'h0);
    lkp("h_t3", 32'h40, 1, 0, 32'h44);
    upd("h_t4", 32'h40, 1, 32'h100, 0, 32'h0);
    lkp("h_t4", 32'h40, 1, 1, 32'h100);
    chk_stats("hyst");

    // Taken with wrong predicted target is a mispredict; target retrained
    upd("tgt_mp", 32'h40, 1, 32'h140, 1, 32'h100);
    lkp("tgt_mp", 32'h40, 1, 1, 32'h140);

    // Aliasing: same index, different tag
    upd("alias_n", 32'h80, 0, 32'h0, 0, 32'h0);
    lkp("alias_keep40", 32'h40, 1, 1, 32'h140);
    lkp("alias_miss80", 32'h80, 0, 0, 32'h84);
    upd("alias_t", 32'h80, 1, 32'h200, 0, 32'h0);
    lkp("alias_evict40", 32'h40, 0, 0, 32'h44);
    lkp("alias_hit80", 32'h80, 1, 1, 32'h200);

    // Other index is independent; PC+4 wraps around the top of memory
    upd("idx1", 32'h44, 1, 32'h300, 0, 32'h0);
    lkp("idx1", 32'h44, 1, 1, 32'h300);
    lkp("idx0_still", 32'h80, 1, 1, 32'h200);
    lkp("wrap", 32'hFFFF_FFFC, 0, 0, 32'h0);

    // No update when upd_valid is low
    bus.upd_taken = 1'b1;
    bus.upd_pred_taken = 1'b0;
    #1;
    chk("idle.mispredict", 32'(bus.upd_mispredict), 32'h0);

    // Same-cycle lookup and update: old contents seen, new state next cycle
    upd("sc_alloc", 32'h40, 1, 32'h100, 0, 32'h0);
    bus.lkp_pc = 32'h40;
    bus.upd_valid = 1'b1;
    bus.upd_pc = 32'h40;
    bus.upd_taken = 1'b0;
    bus.upd_pred_taken = 1'b1;
    bus.upd_pred_target = 32'h100;
    #1;
    chk("sc.taken_old", 32'(bus.lkp_taken), 32'h1);
    chk("sc.mispredict", 32'(bus.upd_mispredict), 32'h1);
    exp_br++;
    exp_mp++;
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
    lkp("sc_new", 32'h40, 1, 0, 32'h44);
    chk_stats("sc");

    // Clear overrides a concurrent taken update but statistics still count it
    bus.bp_clear = 1'b1;
    upd("clr", 32'h48, 1, 32'h400, 0, 32'h0);
    bus.bp_clear = 1'b0;
    lkp("clr40", 32'h40, 0, 0, 32'h44);
    lkp("clr44", 32'h44, 0, 0, 32'h48);
    lkp("clr48", 32'h48, 0, 0, 32'h4C);
    chk_stats("clr");
    // Counter restarts from weakly-taken on re-allocation after clear
    upd("clr_realloc", 32'h44, 1, 32'h500, 0, 32'h0);
    lkp("clr_realloc", 32'h44, 1, 1, 32'h500);

    // Async reset asserted mid-update
    bus.upd_valid = 1'b1;
    bus.upd_pc = 32'h50;
    bus.upd_taken = 1'b1;
    bus.upd_target = 32'h600;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.branches", bus.stat_branches, 32'h0);
    chk("arst.mispredicts", bus.stat_mispredicts, 32'h0);
    lkp("arst44", 32'h44, 0, 0, 32'h48);
    @(posedge clk);
    @(negedge clk);
    bus.upd_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    lkp("arst50", 32'h50, 0, 0, 32'h54);
    exp_br = 0;
    exp_mp = 0;
    chk_stats("arst_after");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
